// File: rtl/sw_pkg.sv
// Shared defaults and state type for the slide-switch conditioning slice.
// Imported by the per-channel debouncer and the top-level event logic.
package sw_pkg;

  localparam int N_SW_DEF        = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 1_000_000;

  typedef enum logic {
    ST_STABLE,
    ST_COUNT
  } db_state_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser chain, debounce FSM and counter,
// committed level plus registered one-cycle rise/fall pulses.
module sw_debounce_ch
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sw_debounce_ch: SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("sw_debounce_ch: DB_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A change commits only after DB_CYCLES consecutive mismatching cycles;
  // any return to the committed level restarts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s != db_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (s == db_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          db_d    = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning top: N_SW debounced channels plus a sticky
// change mask with a valid/ack handshake for slower consumers.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N_SW        = N_SW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] evt_mask,
  output logic            evt_valid,
  input  logic            evt_ack
);

  logic [N_SW-1:0] evt_mask_q, evt_mask_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk_i (CLK),
      .rst_i (RST),
      .sw_i  (sw_in[i]),
      .db_o  (sw_db[i]),
      .rise_o(sw_rise[i]),
      .fall_o(sw_fall[i])
    );
  end

  // Pulses arriving in the ack cycle are OR'd in after the clear, so no edge is lost.
  always_comb begin
    evt_mask_d = (evt_ack && evt_valid) ? '0 : evt_mask_q;
    evt_mask_d = evt_mask_d | sw_rise | sw_fall;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      evt_mask_q <= '0;
    end else begin
      evt_mask_q <= evt_mask_d;
    end
  end

  assign evt_mask  = evt_mask_q;
  assign evt_valid = |evt_mask_q;

endmodule
